// File: rtl/cfg_bus_pkg.sv
// Shared definitions for the per-neuron serial configuration bus.
// Used by the bus master and by the neuron-side receivers.
package cfg_bus_pkg;

    typedef logic [2:0] cfg_state_t;

    localparam cfg_state_t StIdle       = 3'd0;
    localparam cfg_state_t StShiftHdr   = 3'd1;
    localparam cfg_state_t StShiftWdata = 3'd2;
    localparam cfg_state_t StShiftRdata = 3'd3;
    localparam cfg_state_t StWaitAck    = 3'd4;
    localparam cfg_state_t StDone       = 3'd5;

    localparam logic RnwRead  = 1'b1;
    localparam logic RnwWrite = 1'b0;

    // Header is the RNW bit followed by the register address.
    function automatic int unsigned hdr_len(input int unsigned addr_width);
        return 1 + addr_width;
    endfunction

    function automatic int unsigned frame_len(input int unsigned addr_width,
                                              input int unsigned fp_width);
        return hdr_len(addr_width) + fp_width;
    endfunction

endpackage

// File: rtl/cfg_serial_master_if.sv
// Request/response handshake plus serial bus lines of the configuration master.
interface cfg_serial_master_if #(
    parameter int unsigned NumTargets = 9,
    parameter int unsigned FpWidth    = 8,
    parameter int unsigned AddrWidth  = 4
);
    localparam int unsigned TgtWidth = $clog2(NumTargets);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rnw;
    logic [TgtWidth-1:0]   req_target;
    logic [AddrWidth-1:0]  req_addr;
    logic [FpWidth-1:0]    req_wdata;
    logic                  rsp_valid;
    logic [FpWidth-1:0]    rsp_rdata;
    logic                  rsp_error;
    logic                  busy;
    logic [NumTargets-1:0] csn;
    logic                  sin;
    logic [NumTargets-1:0] sout;
    logic [NumTargets-1:0] sack;

    modport master (
        input  req_valid, req_rnw, req_target, req_addr, req_wdata, sout, sack,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, busy, csn, sin
    );

    modport slave (
        output req_valid, req_rnw, req_target, req_addr, req_wdata, sout, sack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy, csn, sin
    );

endinterface

// File: rtl/cfg_shift_reg.sv
// Loadable PISO/SIPO shift register; shifts towards the MSB, serial out is the MSB.
module cfg_shift_reg #(
    parameter int unsigned Width    = 13,
    parameter int unsigned OutWidth = 8
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                load,
    input  logic [Width-1:0]    load_data,
    input  logic                shift_en,
    input  logic                ser_in,
    output logic                ser_out,
    output logic [OutWidth-1:0] par_out
);

    logic [Width-1:0] sr_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= load_data;
        end else if (shift_en) begin
            sr_q <= {sr_q[Width-2:0], ser_in};
        end
    end

    assign ser_out = sr_q[Width-1];
    // Only the most recently shifted-in bits carry read data.
    assign par_out = sr_q[OutWidth-1:0];

endmodule

// File: rtl/cfg_serial_master.sv
// Bit-serial configuration initiator: turns parallel register requests into
// CSN/SIN/SOUT/SACK frames towards one selected neuron.
module cfg_serial_master
    import cfg_bus_pkg::*;
#(
    parameter int unsigned NumTargets = 9,
    parameter int unsigned FpWidth    = 8,
    parameter int unsigned AddrWidth  = 4,
    parameter int unsigned AckTimeout = 255
) (
    input logic CLK,
    input logic RSTN,
    cfg_serial_master_if.master bus
);

    localparam int unsigned HdrLen    = hdr_len(AddrWidth);
    localparam int unsigned FrameLen  = frame_len(AddrWidth, FpWidth);
    localparam int unsigned TgtWidth  = $clog2(NumTargets);
    localparam int unsigned CntWidth  = $clog2(FrameLen);
    localparam int unsigned WaitWidth = $clog2(AckTimeout + 1);

    localparam logic [TgtWidth:0]    NumTgtLimit = (TgtWidth + 1)'(NumTargets);
    localparam logic [CntWidth-1:0]  HdrLast     = CntWidth'(HdrLen - 1);
    localparam logic [CntWidth-1:0]  DataLast    = CntWidth'(FpWidth - 1);
    localparam logic [WaitWidth-1:0] WaitLast    = WaitWidth'(AckTimeout);

    cfg_state_t           state_q, state_d;
    logic [TgtWidth-1:0]  tgt_q, tgt_d;
    logic                 rnw_q, rnw_d;
    logic                 err_q, err_d;
    logic [CntWidth-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WaitWidth-1:0] wait_cnt_q, wait_cnt_d;

    logic                  tgt_ok;
    logic                  frame_active;
    logic [NumTargets-1:0] sel;
    logic                  sel_sout;
    logic                  sel_sack;
    logic                  sr_load;
    logic                  sr_shift;
    logic                  sr_ser_out;
    logic [FpWidth-1:0]    sr_par;

    assign tgt_ok = ({1'b0, bus.req_target} < NumTgtLimit);

    assign frame_active = (state_q == StShiftHdr) || (state_q == StShiftWdata) ||
                          (state_q == StShiftRdata) || (state_q == StWaitAck);

    // One-hot select of the addressed neuron; an out-of-range index selects none.
    always_comb begin
        sel = '0;
        if (frame_active) begin
            for (int i = 0; i < NumTargets; i++) begin
                if (tgt_q == TgtWidth'(i)) begin
                    sel[i] = 1'b1;
                end
            end
        end
    end

    assign sel_sout = |(bus.sout & sel);
    assign sel_sack = |(bus.sack & sel);

    assign sr_load  = (state_q == StIdle) && bus.req_valid && tgt_ok;
    assign sr_shift = (state_q == StShiftHdr) || (state_q == StShiftWdata) ||
                      (state_q == StShiftRdata);

    cfg_shift_reg #(
        .Width    (FrameLen),
        .OutWidth (FpWidth)
    ) u_shift_reg (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .load      (sr_load),
        .load_data ({bus.req_rnw, bus.req_addr, bus.req_wdata}),
        .shift_en  (sr_shift),
        .ser_in    (sel_sout),
        .ser_out   (sr_ser_out),
        .par_out   (sr_par)
    );

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        rnw_d      = rnw_q;
        err_d      = err_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    tgt_d     = bus.req_target;
                    rnw_d     = bus.req_rnw;
                    bit_cnt_d = '0;
                    err_d     = !tgt_ok;
                    state_d   = tgt_ok ? StShiftHdr : StDone;
                end
            end
            StShiftHdr: begin
                if (bit_cnt_q == HdrLast) begin
                    bit_cnt_d = '0;
                    state_d   = (rnw_q == RnwRead) ? StShiftRdata : StShiftWdata;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StShiftWdata, StShiftRdata: begin
                if (bit_cnt_q == DataLast) begin
                    bit_cnt_d  = '0;
                    wait_cnt_d = WaitWidth'(1);
                    state_d    = StWaitAck;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StWaitAck: begin
                if (sel_sack) begin
                    state_d = StDone;
                end else if (wait_cnt_q == WaitLast) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= StIdle;
            tgt_q      <= '0;
            rnw_q      <= RnwWrite;
            err_q      <= 1'b0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            rnw_q      <= rnw_d;
            err_q      <= err_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Header bits go out for both directions; data bits only for writes.
    assign bus.sin = ((state_q == StShiftHdr) || (state_q == StShiftWdata)) ? sr_ser_out : 1'b0;
    assign bus.csn = ~sel;

    assign bus.req_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.rsp_valid = (state_q == StDone);
    assign bus.rsp_error = (state_q == StDone) && err_q;
    assign bus.rsp_rdata = ((state_q == StDone) && (rnw_q == RnwRead) && !err_q) ? sr_par : '0;

endmodule

// File: tb/tb_cfg_serial_master.sv
// Randomized self-checking bench for cfg_serial_master against a cycle-timing model.
module tb_cfg_serial_master;

    localparam int unsigned NT  = 9;
    localparam int unsigned FW  = 8;
    localparam int unsigned AW  = 4;
    localparam int unsigned TO  = 4;
    localparam int unsigned H   = 1 + AW;
    localparam int unsigned FL  = H + FW;
    localparam int          WST = 1 + FL;  // first WAIT_ACK cycle

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;

    always #5 CLK = ~CLK;

    cfg_serial_master_if #(
        .NumTargets (NT),
        .FpWidth    (FW),
        .AddrWidth  (AW)
    ) bus ();

    cfg_serial_master #(
        .NumTargets (NT),
        .FpWidth    (FW),
        .AddrWidth  (AW),
        .AckTimeout (TO)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full transaction from the accept cycle (cycle 0) to one cycle after the response.
    // sack_cyc is the cycle in which SACK[tgt] is pulsed; outside the wait window means none.
    task automatic run_txn(input logic rnw, input int tgt, input logic [AW-1:0] addr,
                           input logic [FW-1:0] wdata, input logic [FW-1:0] rdata,
                           input int sack_cyc);
        logic              bad;
        logic              exp_err;
        int                done;
        logic [FL-1:0]     frame;
        logic [NT-1:0]     exp_csn;
        logic              exp_sin;
        logic [FW-1:0]     exp_rdata;
        bad   = (tgt >= NT);
        frame = {rnw, addr, wdata};
        if (bad) begin
            done    = 1;
            exp_err = 1'b1;
        end else if (sack_cyc >= WST && sack_cyc <= WST + TO - 1) begin
            done    = sack_cyc + 1;
            exp_err = 1'b0;
        end else begin
            done    = WST + TO;
            exp_err = 1'b1;
        end
        exp_rdata = (rnw && !exp_err) ? rdata : '0;

        @(posedge CLK); #1;
        check_eq("ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_rnw    = rnw;
        bus.req_target = 4'(tgt);
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.sout       = NT'($urandom);
        bus.sack       = NT'($urandom);

        for (int c = 1; c <= done + 1; c++) begin
            @(posedge CLK); #1;
            bus.req_valid  = 1'b0;
            bus.req_rnw    = 1'($urandom);
            bus.req_target = 4'($urandom);
            bus.req_addr   = AW'($urandom);
            bus.req_wdata  = FW'($urandom);
            bus.sout       = NT'($urandom);
            bus.sack       = NT'($urandom);
            if (!bad && rnw && c >= 1 + H && c <= FL) begin
                bus.sout[tgt] = rdata[FW - 1 - (c - 1 - int'(H))];
            end
            if (!bad && c >= WST) begin
                bus.sack[tgt] = (c == sack_cyc);
            end
            #1;
            exp_csn = '1;
            if (!bad && c < done) exp_csn[tgt] = 1'b0;
            exp_sin = 1'b0;
            if (!bad && c <= FL && ((c - 1) < H || !rnw)) exp_sin = frame[FL - c];
            check_eq("csn", 32'(bus.csn), 32'(exp_csn));
            check_eq("sin", 32'(bus.sin), 32'(exp_sin));
            check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(c == done));
            check_eq("busy", 32'(bus.busy), 32'(c <= done));
            if (c == done) begin
                check_eq("rsp_error", 32'(bus.rsp_error), 32'(exp_err));
                check_eq("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
            end
            if (c == done + 1) begin
                check_eq("ready_after", 32'(bus.req_ready), 32'd1);
            end
        end
        bus.sout = '0;
        bus.sack = '0;
    endtask

    initial begin
        int tgt;
        bus.req_valid  = 1'b0;
        bus.req_rnw    = 1'b0;
        bus.req_target = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.sout       = '0;
        bus.sack       = '0;

        #12;
        check_eq("rst_csn", 32'(bus.csn), 32'(9'h1ff));
        check_eq("rst_sin", 32'(bus.sin), 32'd0);
        check_eq("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_error", 32'(bus.rsp_error), 32'd0);
        check_eq("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        #11 RSTN = 1'b1;

        run_txn(1'b0, 3, 4'h5, 8'hA7, 8'h00, 14);
        run_txn(1'b1, 8, 4'hC, 8'h00, 8'h3E, 14);
        run_txn(1'b0, 0, 4'h9, 8'h5A, 8'h00, 0);
        run_txn(1'b0, 12, 4'h1, 8'hFF, 8'h00, 0);
        run_txn(1'b0, 2, 4'h7, 8'h81, 8'h00, 16);

        // Reset in the middle of a write frame
        @(posedge CLK); #1;
        bus.req_valid  = 1'b1;
        bus.req_rnw    = 1'b0;
        bus.req_target = 4'd1;
        bus.req_addr   = 4'h3;
        bus.req_wdata  = 8'hFF;
        for (int c = 1; c <= 6; c++) begin
            @(posedge CLK); #1;
            bus.req_valid = 1'b0;
        end
        @(posedge CLK); #3;
        RSTN = 1'b0;
        #1;
        check_eq("midrst_csn", 32'(bus.csn), 32'(9'h1ff));
        check_eq("midrst_sin", 32'(bus.sin), 32'd0);
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_valid", 32'(bus.rsp_valid), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge CLK); #1;
            check_eq("midrst_hold_valid", 32'(bus.rsp_valid), 32'd0);
            check_eq("midrst_hold_csn", 32'(bus.csn), 32'(9'h1ff));
        end
        #2 RSTN = 1'b1;
        run_txn(1'b0, 4, 4'hA, 8'h3C, 8'h00, 15);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) tgt = int'($urandom_range(NT, 15));
            else tgt = int'($urandom_range(0, NT - 1));
            run_txn(1'($urandom), tgt, AW'($urandom), FW'($urandom), FW'($urandom),
                    int'($urandom_range(WST, WST + TO)));
            repeat ($urandom_range(0, 2)) @(posedge CLK);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
